// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, FSM states and line layout
// for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int DC_NUM_LINES      = 8;
    localparam int DC_WORDS_PER_LINE = 4;
    localparam int DC_ADDR_W         = 32;

    function automatic int offset_w(input int wpl);
        return $clog2(wpl);
    endfunction

    function automatic int index_w(input int nl);
        return $clog2(nl);
    endfunction

    function automatic int tag_w(input int aw, input int nl, input int wpl);
        return aw - $clog2(nl) - $clog2(wpl) - 2;
    endfunction

    localparam int OFFSET_W = offset_w(DC_WORDS_PER_LINE);
    localparam int INDEX_W  = index_w(DC_NUM_LINES);
    localparam int TAG_W    = tag_w(DC_ADDR_W, DC_NUM_LINES, DC_WORDS_PER_LINE);
    localparam int LINE_W   = 32 * DC_WORDS_PER_LINE;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        FLUSH_SCAN,
        FLUSH_WB
    } state_e;

    // Line geometry is fixed by the package defaults above.
    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } line_t;

endpackage

// File: rtl/dcache_direct_wb_if.sv
// dcache_direct_wb_if: line-wide memory bus between the
// data cache (master) and the data memory model (slave).
interface dcache_direct_wb_if
    import dcache_pkg::*;
#(
    parameter int ADDR_W         = DC_ADDR_W,
    parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE
);
    logic                        dmem_req;
    logic                        dmem_we;
    logic [ADDR_W-1:0]           dmem_addr;
    logic [32*WORDS_PER_LINE-1:0] dmem_wdata;
    logic [32*WORDS_PER_LINE-1:0] dmem_rdata;
    logic                        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/dcache_tag_data_array.sv
// dcache_tag_data_array: line storage with one combinational
// read port and one synchronous line/word write port.
module dcache_tag_data_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = DC_NUM_LINES,
    parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               inv_all_i,
    input  logic [index_w(NUM_LINES)-1:0]      rd_idx_i,
    output line_t                              rd_line_o,
    input  logic [index_w(NUM_LINES)-1:0]      wr_idx_i,
    input  logic                               wr_line_en_i,
    input  line_t                              wr_line_i,
    input  logic                               wr_word_en_i,
    input  logic [offset_w(WORDS_PER_LINE)-1:0] wr_off_i,
    input  logic [31:0]                        wr_word_i,
    input  logic                               clr_dirty_i
);
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    // Status bits: reset and flush clear them, writes update them.
    always_ff @(posedge clk) begin
        if (reset || inv_all_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_line_en_i) begin
            valid_q[wr_idx_i] <= wr_line_i.valid;
            dirty_q[wr_idx_i] <= wr_line_i.dirty;
        end else if (wr_word_en_i) begin
            dirty_q[wr_idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[wr_idx_i] <= 1'b0;
        end
    end

    // Tag and data payload; no reset needed behind the valid bit.
    always_ff @(posedge clk) begin
        if (wr_line_en_i) begin
            tag_q[wr_idx_i]  <= wr_line_i.tag;
            data_q[wr_idx_i] <= wr_line_i.data;
        end else if (wr_word_en_i) begin
            data_q[wr_idx_i][{wr_off_i, 5'b0} +: 32] <= wr_word_i;
        end
    end

    // Combinational read of the addressed line.
    always_comb begin
        rd_line_o.valid = valid_q[rd_idx_i];
        rd_line_o.dirty = dirty_q[rd_idx_i];
        rd_line_o.tag   = tag_q[rd_idx_i];
        rd_line_o.data  = data_q[rd_idx_i];
    end

endmodule

// File: rtl/dcache_direct_wb.sv
// dcache_direct_wb: direct-mapped write-back write-allocate
// L1 data cache with whole-cache flush.
module dcache_direct_wb
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = DC_NUM_LINES,
    parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE,
    parameter int ADDR_W         = DC_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              requested_data_to_mem,
    dcache_direct_wb_if.master dmem
);
    localparam int OW = offset_w(WORDS_PER_LINE);
    localparam int IW = index_w(NUM_LINES);
    localparam int TW = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);

    state_e         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic           flush_pend_q, flush_pend_d;

    logic [OW-1:0]  off;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  tag;
    logic           req;
    logic           hit;
    logic           in_flush;
    logic [IW-1:0]  rd_idx;
    line_t          line;
    line_t          fill_line;
    logic [31:0]    word;
    logic           unused_addr_bits;

    logic           inv_all;
    logic           wr_line_en;
    logic           wr_word_en;
    logic           clr_dirty;

    assign off = address[OW+1:2];
    assign idx = address[OW+2 +: IW];
    assign tag = address[ADDR_W-1 -: TW];
    assign unused_addr_bits = ^address[1:0];

    assign req      = mem_read | mem_write;
    assign in_flush = (state_q == FLUSH_SCAN) || (state_q == FLUSH_WB);
    assign rd_idx   = in_flush ? ptr_q : idx;
    assign hit      = line.valid && (line.tag == tag) && req;
    assign word     = line.data[{off, 5'b0} +: 32];

    assign fill_line.valid = 1'b1;
    assign fill_line.dirty = 1'b0;
    assign fill_line.tag   = tag;
    assign fill_line.data  = dmem.dmem_rdata;

    dcache_tag_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk          (clk),
        .reset        (reset),
        .inv_all_i    (inv_all),
        .rd_idx_i     (rd_idx),
        .rd_line_o    (line),
        .wr_idx_i     (rd_idx),
        .wr_line_en_i (wr_line_en),
        .wr_line_i    (fill_line),
        .wr_word_en_i (wr_word_en),
        .wr_off_i     (off),
        .wr_word_i    (writedata),
        .clr_dirty_i  (clr_dirty)
    );

    // FSM state, flush scan pointer and pending-flush latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Next state, stall, memory bus and array write controls.
    always_comb begin
        state_d               = state_q;
        ptr_d                 = ptr_q;
        flush_pend_d          = flush_pend_q | flush;
        requested_data_to_mem = 1'b1;
        readdata              = '0;
        dmem.dmem_req         = 1'b0;
        dmem.dmem_we          = 1'b0;
        dmem.dmem_addr        = '0;
        dmem.dmem_wdata       = '0;
        inv_all               = 1'b0;
        wr_line_en            = 1'b0;
        wr_word_en            = 1'b0;
        clr_dirty             = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) begin
                    state_d      = FLUSH_SCAN;
                    ptr_d        = '0;
                    flush_pend_d = 1'b0;
                end else if (!req) begin
                    requested_data_to_mem = 1'b0;
                end else if (hit) begin
                    requested_data_to_mem = 1'b0;
                    if (mem_write) begin
                        wr_word_en = 1'b1;
                    end else begin
                        readdata = word;
                    end
                end else if (line.valid && line.dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = REFILL;
                end
            end
            WRITEBACK: begin
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = 1'b1;
                dmem.dmem_addr  = {line.tag, rd_idx, {(OW+2){1'b0}}};
                dmem.dmem_wdata = line.data;
                if (dmem.dmem_ready) begin
                    clr_dirty = 1'b1;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                dmem.dmem_req  = 1'b1;
                dmem.dmem_addr = {tag, idx, {(OW+2){1'b0}}};
                if (dmem.dmem_ready) begin
                    wr_line_en = 1'b1;
                    state_d    = IDLE;
                end
            end
            FLUSH_SCAN: begin
                if (line.valid && line.dirty) begin
                    state_d = FLUSH_WB;
                end else if (ptr_q == IW'(NUM_LINES-1)) begin
                    inv_all = 1'b1;
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            FLUSH_WB: begin
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = 1'b1;
                dmem.dmem_addr  = {line.tag, rd_idx, {(OW+2){1'b0}}};
                dmem.dmem_wdata = line.data;
                if (dmem.dmem_ready) begin
                    clr_dirty = 1'b1;
                    if (ptr_q == IW'(NUM_LINES-1)) begin
                        inv_all = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = FLUSH_SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// tb_dcache_direct_wb: directed checks of the data cache
// against a latency-3 line memory and a word reference image.
module tb_dcache_direct_wb;
    import dcache_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        stall;

    dcache_direct_wb_if #(.ADDR_W(32), .WORDS_PER_LINE(4)) dmem_if ();

    dcache_direct_wb #(
        .NUM_LINES      (8),
        .WORDS_PER_LINE (4),
        .ADDR_W         (32)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .flush                 (flush),
        .mem_read              (mem_read),
        .mem_write             (mem_write),
        .address               (address),
        .writedata             (writedata),
        .readdata              (readdata),
        .requested_data_to_mem (stall),
        .dmem                  (dmem_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    logic [127:0] mem [logic [31:0]];
    logic [31:0]  ref_w [logic [31:0]];
    logic         log_we [$];
    logic [31:0]  log_addr [$];
    logic [127:0] log_wdata [$];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [127:0] pat_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = pat(la + 32'(4*k));
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return ref_w.exists(a) ? ref_w[a] : pat(a);
    endfunction

    function automatic logic [127:0] exp_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = exp_word(la + 32'(4*k));
        return l;
    endfunction

    function automatic int count_we(input logic we);
        int n = 0;
        foreach (log_we[i]) if (log_we[i] == we) n++;
        return n;
    endfunction

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_wdata.delete();
    endtask

    // Line memory: ready pulses on the LAT-th cycle of a request.
    initial begin
        int cnt;
        cnt = 0;
        dmem_if.dmem_ready = 1'b0;
        dmem_if.dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset || dmem_if.dmem_ready) begin
                dmem_if.dmem_ready = 1'b0;
                cnt = 0;
            end else if (dmem_if.dmem_req) begin
                cnt++;
                if (cnt == LAT) begin
                    log_we.push_back(dmem_if.dmem_we);
                    log_addr.push_back(dmem_if.dmem_addr);
                    log_wdata.push_back(dmem_if.dmem_wdata);
                    if (dmem_if.dmem_we)
                        mem[dmem_if.dmem_addr] = dmem_if.dmem_wdata;
                    else if (mem.exists(dmem_if.dmem_addr))
                        dmem_if.dmem_rdata = mem[dmem_if.dmem_addr];
                    else
                        dmem_if.dmem_rdata = pat_line(dmem_if.dmem_addr);
                    dmem_if.dmem_ready = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cpu(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rdata, output int stalls);
        @(negedge clk);
        mem_read = rd;
        mem_write = wr;
        address = a;
        writedata = wd;
        stalls = 0;
        #1;
        while (stall && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 200) chk("cpu_timeout", 128'(stalls), 128'(0));
        rdata = readdata;
        if (wr) ref_w[a] = wd;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_flush(output int cycles);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_stall", 128'(stall), 128'(1));
        cycles = 0;
        while (stall && cycles < 500) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        if (cycles >= 500) chk("flush_timeout", 128'(cycles), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int st;
        int cyc;

        mem[32'h0] = {32'h44, 32'h33, 32'h22, 32'h11};
        ref_w[32'h0] = 32'h11;
        ref_w[32'h4] = 32'h22;
        ref_w[32'h8] = 32'h33;
        ref_w[32'hC] = 32'h44;

        do_reset();
        #1;
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_req", 128'(dmem_if.dmem_req), 128'(0));
        chk("rst_we", 128'(dmem_if.dmem_we), 128'(0));
        chk("rst_addr", 128'(dmem_if.dmem_addr), 128'(0));
        chk("rst_wdata", dmem_if.dmem_wdata, 128'(0));
        chk("rst_rdata", 128'(readdata), 128'(0));

        // Cold read miss.
        clear_log();
        cpu(1, 0, 32'h00, 0, rd, st);
        chk("t1_stalls", 128'(st), 128'(4));
        chk("t1_nxact", 128'(log_we.size()), 128'(1));
        chk("t1_fill_we", 128'(log_we[0]), 128'(0));
        chk("t1_fill_addr", 128'(log_addr[0]), 128'(0));
        chk("t1_rdata", 128'(rd), 128'(32'h11));
        cpu(1, 0, 32'h0C, 0, rd, st);
        chk("t1_hit_stalls", 128'(st), 128'(0));
        chk("t1_hit_rdata", 128'(rd), 128'(32'h44));

        // Write hit then dirty eviction.
        clear_log();
        cpu(0, 1, 32'h04, 32'hDEADBEEF, rd, st);
        chk("t2_whit_stalls", 128'(st), 128'(0));
        cpu(1, 0, 32'h84, 0, rd, st);
        chk("t2_nxact", 128'(log_we.size()), 128'(2));
        chk("t2_wb_we", 128'(log_we[0]), 128'(1));
        chk("t2_wb_addr", 128'(log_addr[0]), 128'(0));
        chk("t2_wb_w1", 128'(log_wdata[0][63:32]), 128'(32'hDEADBEEF));
        chk("t2_wb_line", log_wdata[0], exp_line(32'h00));
        chk("t2_fill_we", 128'(log_we[1]), 128'(0));
        chk("t2_fill_addr", 128'(log_addr[1]), 128'(32'h80));
        chk("t2_rdata", 128'(rd), 128'(exp_word(32'h84)));

        // Flush with dirty lines at indices 1 and 5.
        cpu(0, 1, 32'h10, 32'hA1A1A1A1, rd, st);
        cpu(0, 1, 32'h58, 32'hB5B5B5B5, rd, st);
        clear_log();
        do_flush(cyc);
        chk("t3_nxact", 128'(log_we.size()), 128'(2));
        chk("t3_wb0_we", 128'(log_we[0]), 128'(1));
        chk("t3_wb0_addr", 128'(log_addr[0]), 128'(32'h10));
        chk("t3_wb0_line", log_wdata[0], exp_line(32'h10));
        chk("t3_wb1_we", 128'(log_we[1]), 128'(1));
        chk("t3_wb1_addr", 128'(log_addr[1]), 128'(32'h50));
        chk("t3_wb1_line", log_wdata[1], exp_line(32'h50));
        clear_log();
        cpu(1, 0, 32'h10, 0, rd, st);
        chk("t3_post_stalls", 128'(st), 128'(4));
        chk("t3_post_fill", 128'(log_addr[0]), 128'(32'h10));
        chk("t3_post_rdata", 128'(rd), 128'(32'hA1A1A1A1));

        // Simultaneous read and write acts as a write.
        cpu(1, 1, 32'h14, 32'h5A5A5A5A, rd, st);
        chk("t4_stalls", 128'(st), 128'(0));
        clear_log();
        cpu(1, 0, 32'h90, 0, rd, st);
        chk("t4_nxact", 128'(log_we.size()), 128'(2));
        chk("t4_wb_we", 128'(log_we[0]), 128'(1));
        chk("t4_wb_addr", 128'(log_addr[0]), 128'(32'h10));
        chk("t4_wb_w1", 128'(log_wdata[0][63:32]), 128'(32'h5A5A5A5A));

        // Reset during a refill.
        clear_log();
        @(negedge clk);
        mem_read = 1'b1;
        address = 32'h200;
        st = 0;
        #1;
        while (!dmem_if.dmem_req && st < 50) begin
            @(negedge clk);
            #1;
            st++;
        end
        chk("t5_req_seen", 128'(dmem_if.dmem_req), 128'(1));
        reset = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_req_drop", 128'(dmem_if.dmem_req), 128'(0));
        chk("t5_stall", 128'(stall), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        cpu(1, 0, 32'h94, 0, rd, st);
        chk("t5_inval_stalls", 128'(st), 128'(4));
        chk("t5_nxact", 128'(log_we.size()), 128'(1));
        chk("t5_rdata", 128'(rd), 128'(exp_word(32'h94)));

        // Sequential generator stream.
        do_reset();
        clear_log();
        for (int i = 0; i < 20; i++) begin
            cpu(1, 0, 32'(4*i), 0, rd, st);
            chk($sformatf("t6_rd_%0h", 4*i), 128'(rd), 128'(exp_word(32'(4*i))));
        end
        chk("t6_rd_fills", 128'(count_we(1'b0)), 128'(5));
        chk("t6_rd_wbs", 128'(count_we(1'b1)), 128'(0));
        clear_log();
        for (int i = 0; i < 8; i++)
            cpu(0, 1, 32'(32'h50 + 4*i), 32'(32'h6000_0000 + i), rd, st);
        chk("t6_wr_fills", 128'(count_we(1'b0)), 128'(2));
        chk("t6_wr_wbs", 128'(count_we(1'b1)), 128'(0));
        clear_log();
        do_flush(cyc);
        chk("t6_fl_nxact", 128'(log_we.size()), 128'(2));
        chk("t6_fl_wb0", 128'(log_addr[0]), 128'(32'h50));
        chk("t6_fl_wb1", 128'(log_addr[1]), 128'(32'h60));
        chk("t6_fl_line0", log_wdata[0], exp_line(32'h50));
        chk("t6_fl_line1", log_wdata[1], exp_line(32'h60));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dcache_direct_wb.md
Name: dcache_direct_wb

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the core's data-access port (or the data-cache request generator on the bench) and the line-wide data memory model.
- Serves word reads/writes on hits with zero added latency.
- Holds the requester off via `requested_data_to_mem` while it writes back a victim, refills a line, or flushes.

Parameters:
- NUM_LINES, 8, number of cache lines (power of 2, ≥2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)
- ADDR_W, 32, byte-address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  one-cycle pulse: write back every dirty line, then invalidate all lines
- mem_read  in  1  CPU word read request
- mem_write  in  1  CPU word write request (wins if both mem_read and mem_write are high)
- address  in  ADDR_W  CPU byte address; bits [1:0] ignored
- writedata  in  32  CPU store data
- readdata  out  32  load data; valid in a cycle where mem_read=1 and requested_data_to_mem=0
- requested_data_to_mem  out  1  stall to requester; request must be held stable while high
- dmem_req  out  1  memory transaction request
- dmem_we  out  1  1 = line write-back, 0 = line fill
- dmem_addr  out  ADDR_W  line-aligned byte address
- dmem_wdata  out  32*WORDS_PER_LINE  victim line data
- dmem_rdata  in  32*WORDS_PER_LINE  fill line data, valid when dmem_ready=1
- dmem_ready  in  1  one-cycle completion of current transaction

Behaviour:
- Address split: offset = [log2(WPL)+1:2], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
- Per-line storage: valid, dirty, tag, data.

Reset:
- All valid and dirty bits cleared; FSM goes to IDLE.
- Outputs: requested_data_to_mem=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, readdata=0.
- Reset mid-transaction aborts immediately; dmem_req drops the next cycle; no partial line is kept.

FSM states: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.

IDLE:
- hit = valid && tag match && (mem_read || mem_write).
- Read hit: readdata combinational from array; requested_data_to_mem=0.
- Write hit: word written at clock edge; dirty set; requested_data_to_mem=0.
- Miss with victim dirty: requested_data_to_mem=1 combinationally the same cycle; next state WRITEBACK.
- Miss with victim clean or invalid: requested_data_to_mem=1 the same cycle; next state REFILL.
- No request: requested_data_to_mem=0.

WRITEBACK:
- dmem_req=1, dmem_we=1, dmem_addr={victim tag, index, 0}, dmem_wdata=victim line.
- On dmem_ready: clear dirty; go to REFILL.

REFILL:
- dmem_req=1, dmem_we=0, dmem_addr=requested line address.
- On dmem_ready: install line with valid=1, dirty=0, new tag; go to IDLE.
- The held request then hits in IDLE on the following cycle.
- Miss penalty: one cycle plus memory latency per transaction.

Stall rule:
- requested_data_to_mem=1 in every non-IDLE state, and in IDLE on a miss.

Flush:
- A flush pulse in IDLE wins over a simultaneous CPU request; the request stays stalled.
- Go to FLUSH_SCAN with pointer=0.
- FLUSH_SCAN: for each line in index order, if dirty go to FLUSH_WB (same signalling as WRITEBACK).
- FLUSH_WB: on dmem_ready, return to FLUSH_SCAN at pointer+1.
- After the last index, all valid bits clear; go to IDLE.
- Flush asserted outside IDLE is latched and serviced on the next IDLE entry.
- requested_data_to_mem=1 for the whole flush.

dmem_req protocol:
- Held high, with stable address and data, until dmem_ready.
- dmem_ready while dmem_req=0 is ignored.

Decomposition:
- Package dcache_pkg: state enum, OFFSET_W/INDEX_W/TAG_W localparam functions, line_t struct {valid, dirty, tag, data}.
- One sub-module, dcache_tag_data_array: the storage array with one combinational read port and one synchronous write port (whole-line or single-word write enable).

Test Plan:
1. Cold read miss:
   - Stimulus: reset, then read 0x00; memory returns line {0x11,0x22,0x33,0x44} after 3 cycles.
   - Required: stall high 4 cycles, a single dmem fill at 0x00, then readdata=0x11.
   - Then read 0x0C → readdata=0x44 with no stall.
2. Write hit then dirty eviction:
   - Stimulus: write 0xDEADBEEF to 0x04; then read 0x84 (same index for NUM_LINES=8, WPL=4).
   - Required: write-back at dmem_addr=0x00 with word1=0xDEADBEEF, followed by a fill at 0x80.
3. Flush:
   - Stimulus: dirty lines at indices 1 and 5; pulse flush.
   - Required: exactly two write-backs (0x10, then 0x50) in order, stall throughout.
   - Afterwards, read 0x10 misses.
4. Simultaneous read and write:
   - Stimulus: mem_read=1 and mem_write=1 to a resident address, writedata=0x5A5A5A5A.
   - Required: treated as a write; line marked dirty.
5. Reset mid-REFILL:
   - Stimulus: assert reset while dmem_req=1.
   - Required: dmem_req=0 the next cycle, all lines invalid, stall=0.
6. Generator stream:
   - Stimulus: 20 sequential reads of 0x00–0x4C, then 8 writes to 0x50–0x6C.
   - Required: exactly 5 fills during the reads and 2 fills during the writes.
   - A subsequent flush produces 2 write-backs (0x50, 0x60).
